// File: rtl/retro16_pkg.sv
// Shared Retro16 fetch definitions: FSM state encoding, no-op word and default vectors.
package retro16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   localparam logic [15:0] NOP_INSTR        = 16'h0000;
   localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
   localparam logic [15:0] DEF_IRQ_VECTOR   = 16'h0010;

   function automatic logic [31:0] pack_entry(input logic [15:0] pc, input logic [15:0] word);
      return {pc, word};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, word} buffer for the fetch stage; the head entry sits in a fixed
// register so the decoder-facing outputs come straight from flops.
module fetch_fifo
   import retro16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [31:0] push_data,
   input  logic        pop,
   input  logic        flush,
   output logic [1:0]  count,
   output logic [31:0] head,
   output logic        head_valid
);

   logic [31:0] entry1_r;
   logic [1:0]  count_next_s;
   logic [1:0]  wr_idx_s;

   // Occupancy after this cycle and the slot a push lands in once any pop has shifted
   always_comb begin
      wr_idx_s = count - {1'b0, pop};
      if (flush) begin
         count_next_s = 2'd0;
      end else begin
         count_next_s = count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage update; a flush only clears occupancy, stale words are never shown as valid
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= 2'd0;
         head       <= pack_entry(16'h0000, NOP_INSTR);
         entry1_r   <= 32'h0000_0000;
         head_valid <= 1'b0;
      end else begin
         count      <= count_next_s;
         head_valid <= (count_next_s != 2'd0);
         if (!flush) begin
            if (pop) begin
               head <= entry1_r;
            end
            if (push) begin
               if (wr_idx_s == 2'd0) begin
                  head <= push_data;
               end else begin
                  entry1_r <= push_data;
               end
            end
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Retro16 instruction fetch: PC, single-outstanding memory handshake, 2-deep buffer, redirect.
// Optional interrupt entry is built only when FETCH_IRQ_EN is defined.
module fetch_unit
   import retro16_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        stall,
`ifdef FETCH_IRQ_EN
   input  logic        irq,
   input  logic        irq_done,
   output logic        irq_ack,
   output logic [15:0] irq_ret_pc,
`endif
   output logic [15:0] instruction,
   output logic [15:0] instr_pc,
   output logic        instr_valid
);

   fetch_state_e state_r;
   logic [15:0]  fetch_pc_r;
   logic [15:0]  next_pc_s;
   logic [1:0]   count_s;
   logic [1:0]   count_after_s;
   logic [31:0]  head_s;
   logic         consume_s, ack_s, push_s, pop_s, flush_s, issue_s, irq_take_s;

`ifdef FETCH_IRQ_EN
   logic         in_service_r;
`else
   logic         unused_irq_vector_s;
   assign unused_irq_vector_s = ^IRQ_VECTOR;
`endif

   fetch_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s),
      .push_data  (pack_entry(fetch_pc_r, mem_rdata)),
      .pop        (pop_s),
      .flush      (flush_s),
      .count      (count_s),
      .head       (head_s),
      .head_valid (instr_valid)
   );

   assign instr_pc    = head_s[31:16];
   assign instruction = head_s[15:0];

   // Handshake decode; an ack also frees the request slot, so a new read can go out
   // in the same cycle and zero-wait memory streams one word per cycle.
   always_comb begin
      consume_s = instr_valid && !stall;
      ack_s     = mem_ack && ((state_r == ST_WAIT) || (state_r == ST_DROP));
`ifdef FETCH_IRQ_EN
      irq_take_s = irq && !in_service_r && !redirect && (state_r == ST_IDLE);
`else
      irq_take_s = 1'b0;
`endif
      flush_s = redirect || irq_take_s;
      push_s  = ack_s && (state_r == ST_WAIT) && !redirect;
      pop_s   = consume_s && !flush_s;
      if (flush_s) begin
         count_after_s = 2'd0;
      end else begin
         count_after_s = count_s + {1'b0, push_s} - {1'b0, pop_s};
      end
      if (redirect) begin
         next_pc_s = redirect_pc;
      end else if (irq_take_s) begin
         next_pc_s = IRQ_VECTOR;
      end else if (push_s) begin
         next_pc_s = fetch_pc_r + 16'd1;
      end else begin
         next_pc_s = fetch_pc_r;
      end
      issue_s = ((state_r == ST_IDLE) || ack_s) && (count_after_s != 2'd2);
   end

   // Request FSM; mem_addr only changes when a fresh request is issued
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         fetch_pc_r <= RESET_VECTOR;
         mem_req    <= 1'b0;
         mem_addr   <= RESET_VECTOR;
      end else begin
         fetch_pc_r <= next_pc_s;
         if (issue_s) begin
            state_r  <= ST_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= next_pc_s;
         end else if (ack_s) begin
            state_r <= ST_IDLE;
            mem_req <= 1'b0;
         end else if (redirect && (state_r == ST_WAIT)) begin
            state_r <= ST_DROP;
         end else begin
            state_r <= state_r;
         end
      end
   end

`ifdef FETCH_IRQ_EN
   // Interrupt entry bookkeeping; the return point is the oldest unexecuted address
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_ack      <= 1'b0;
         irq_ret_pc   <= 16'h0000;
         in_service_r <= 1'b0;
      end else begin
         irq_ack <= irq_take_s;
         if (irq_take_s) begin
            irq_ret_pc   <= instr_valid ? instr_pc : fetch_pc_r;
            in_service_r <= 1'b1;
         end else if (irq_done) begin
            in_service_r <= 1'b0;
         end else begin
            in_service_r <= in_service_r;
         end
      end
   end
`endif

endmodule
